data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder_if.sv | 36 +++
 rtl/data_mem_responder.sv | 209 ++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// -----------------------------------------------------------------------------
// data_mem_responder_if
// Request/response bundle between the core's load/store unit (master) and the
// data memory responder (slave).
//   req_valid / req_ready : request handshake
//   load, store           : opcode (exactly one must be set)
//   xfer_size             : bytes to move (1, 2 or 4)
//   address               : byte address, little-endian
//   wr_data               : store data, right-justified
//   rd_data               : load data, right-justified, zero-padded
//   resp_valid / resp_err : one-cycle completion pulse and its error flag
// -----------------------------------------------------------------------------
interface data_mem_responder_if #(
    parameter int ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic              load;
    logic              store;
    logic [2:0]        xfer_size;
    logic [ADDR_W-1:0] address;
    logic [31:0]       wr_data;
    logic [31:0]       rd_data;
    logic              resp_valid;
    logic              resp_err;

    modport master (
        output req_valid, load, store, xfer_size, address, wr_data,
        input  req_ready, rd_data, resp_valid, resp_err
    );

    modport slave (
        input  req_valid, load, store, xfer_size, address, wr_data,
        output req_ready, rd_data, resp_valid, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Word-organised data RAM answering byte-addressed loads/stores of 1, 2 or 4
// bytes. An access that runs past the end of its word is done in two beats
// (addressed word, then the next word with wrap at DEPTH). Every accepted
// request gets exactly one resp_valid pulse; illegal requests answer with
// resp_err=1 and rd_data=0 and leave the RAM alone.
//
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; returns FSM to IDLE, clears outputs,
//           does not clear the RAM
//   bus   : data_mem_responder_if.slave (request/response bundle)
//
// Build option:
//   MISALIGN_TRAP_EN : when defined, word-crossing accesses are rejected as
//                      illegal (single-beat error response) instead of split.
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Lane mask for a transfer size; zero marks an unsupported size
    function automatic logic [3:0] size_mask(input logic [2:0] size);
        logic [3:0] m;
        case (size)
            3'd1:    m = 4'b0001;
            3'd2:    m = 4'b0011;
            3'd4:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Expand a 4-bit lane mask into a 32-bit bit mask
    function automatic logic [31:0] byte_expand(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    logic [31:0]       mem [DEPTH];

    state_t            state_r;
    state_t            state_next_s;
    logic [ADDR_W-1:0] addr_s;
    logic              unused_addr_s;
    logic              accept_s;
    logic [3:0]        req_mask_s;
    logic [3:0]        span_s;
    logic              cross_s;
    logic              bad_s;
    logic              split_s;

    logic [IDX_W-1:0]  idx_r;
    logic [1:0]        off_r;
    logic [3:0]        mask_r;
    logic [31:0]       wdata_r;
    logic              load_r;
    logic              store_r;
    logic              err_r;
    logic              split_r;
    logic [31:0]       lo_r;

    logic [IDX_W-1:0]  idx_hi_s;
    logic [63:0]       wide_s;
    logic [7:0]        be_s;
    logic [63:0]       pair_s;
    logic [63:0]       shifted_s;
    logic [31:0]       load_data_s;
    logic              wr_lo_s;
    logic              wr_hi_s;

    logic [31:0]       rd_data_r;
    logic              resp_valid_r;
    logic              resp_err_r;

    assign addr_s        = bus.address;
    assign unused_addr_s = ^addr_s[ADDR_W-1:IDX_W+2];
    assign accept_s      = bus.req_valid && bus.req_ready;

    // Classify the incoming request: legality and whether it needs two beats
    always_comb begin
        req_mask_s = size_mask(bus.xfer_size);
        span_s     = {2'b00, addr_s[1:0]} + {1'b0, bus.xfer_size};
        cross_s    = (span_s > 4'd4);
`ifdef MISALIGN_TRAP_EN
        bad_s      = (req_mask_s == 4'b0000) || (bus.load == bus.store) || cross_s;
        split_s    = 1'b0;
`else
        bad_s      = (req_mask_s == 4'b0000) || (bus.load == bus.store);
        split_s    = cross_s && !bad_s;
`endif
    end

    // Beat datapath: store data/enables are shifted into a two-word window,
    // the low word belongs to beat 0 and the high word to beat 1
    always_comb begin
        idx_hi_s  = idx_r + IDX_W'(1);
        wide_s    = {32'h0000_0000, wdata_r} << {off_r, 3'b000};
        be_s      = {4'b0000, mask_r} << off_r;
        if (state_r == BEAT1) begin
            pair_s = {mem[idx_hi_s], lo_r};
        end else begin
            pair_s = {32'h0000_0000, mem[idx_r]};
        end
        shifted_s   = pair_s >> {off_r, 3'b000};
        load_data_s = shifted_s[31:0] & byte_expand(mask_r);
        wr_lo_s     = (state_r == BEAT0) && store_r && !err_r && !reset;
        wr_hi_s     = (state_r == BEAT1) && store_r && !err_r && !reset;
    end

    // RAM byte-lane writes (contents survive reset)
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_lo_s && be_s[b]) begin
                mem[idx_r][8*b +: 8] <= wide_s[8*b +: 8];
            end else if (wr_hi_s && be_s[b+4]) begin
                mem[idx_hi_s][8*b +: 8] <= wide_s[32+8*b +: 8];
            end
        end
    end

    // Request capture at accept, plus the beat-0 word kept for split loads
    always_ff @(posedge clk) begin
        if (accept_s) begin
            idx_r   <= addr_s[IDX_W+1:2];
            off_r   <= addr_s[1:0];
            mask_r  <= size_mask(bus.xfer_size);
            wdata_r <= bus.wr_data;
            load_r  <= bus.load;
            store_r <= bus.store;
            err_r   <= bad_s;
            split_r <= split_s;
        end
        if (state_r == BEAT0) begin
            lo_r <= mem[idx_r];
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = IDLE;
        case (state_r)
            IDLE: begin
                if (accept_s) state_next_s = BEAT0;
                else          state_next_s = IDLE;
            end
            BEAT0: begin
                if (split_r) state_next_s = BEAT1;
                else         state_next_s = RESP;
            end
            BEAT1:   state_next_s = RESP;
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // FSM outputs: ready only in IDLE and never while reset is asserted
    always_comb begin
        if ((state_r == IDLE) && !reset) begin
            bus.req_ready = 1'b1;
        end else begin
            bus.req_ready = 1'b0;
        end
    end

    // Response registers, loaded on the edge that enters RESP
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            rd_data_r    <= 32'h0000_0000;
        end else begin
            resp_valid_r <= (state_next_s == RESP);
            resp_err_r   <= (state_next_s == RESP) && err_r;
            if (state_next_s == RESP) begin
                rd_data_r <= (load_r && !err_r) ? load_data_s : 32'h0000_0000;
            end else begin
                rd_data_r <= rd_data_r;
            end
        end
    end

    assign bus.rd_data    = rd_data_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_err   = resp_err_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
// Directed-vector bench for data_mem_responder (DEPTH=256, ADDR_W=32).
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// Latency is counted in rising edges after the accepting edge.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    data_mem_responder_if #(.ADDR_W(32)) bus_if ();

    data_mem_responder #(.DEPTH(256), .ADDR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one request, wait for its response; inputs are scrambled after accept
    task automatic xact(input logic l, input logic s, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err,
                        output int lat, output logic pulse_after);
        int n;
        @(negedge clk);
        bus_if.req_valid = 1'b1;
        bus_if.load      = l;
        bus_if.store     = s;
        bus_if.xfer_size = sz;
        bus_if.address   = a;
        bus_if.wr_data   = wd;
        n = 0;
        while (!bus_if.req_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        bus_if.load      = 1'b1;
        bus_if.store     = 1'b1;
        bus_if.xfer_size = 3'd7;
        bus_if.address   = 32'hFFFF_FFFF;
        bus_if.wr_data   = 32'h5A5A_5A5A;
        lat = 0;
        while (!bus_if.resp_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        rd  = bus_if.rd_data;
        err = bus_if.resp_err;
        @(negedge clk);
        pulse_after = bus_if.resp_valid;
    endtask

    task automatic run(input string tag, input logic l, input logic s, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input int exp_lat, input bit chk_rd);
        logic [31:0] rd;
        logic        err;
        int          lat;
        logic        pulse_after;
        xact(l, s, sz, a, wd, rd, err, lat, pulse_after);
        check_eq({tag, "/err"}, {31'b0, err}, {31'b0, exp_err});
        check_eq({tag, "/lat"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "/pulse"}, {31'b0, pulse_after}, 32'h0);
        if (chk_rd) check_eq({tag, "/rd"}, rd, exp_rd);
    endtask

    initial begin
        int acc;
        int rsp;
        int ov;
        int bad;
        int n;
        logic [31:0] w4;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus_if.req_valid = 1'b0;
        bus_if.load      = 1'b0;
        bus_if.store     = 1'b0;
        bus_if.xfer_size = 3'd0;
        bus_if.address   = 32'h0;
        bus_if.wr_data   = 32'h0;

        // Reset state, with req_valid asserted to show it is ignored
        repeat (3) @(negedge clk);
        bus_if.req_valid = 1'b1;
        bus_if.load      = 1'b1;
        bus_if.xfer_size = 3'd4;
        @(negedge clk);
        check_eq("rst/ready", {31'b0, bus_if.req_ready}, 32'h0);
        check_eq("rst/valid", {31'b0, bus_if.resp_valid}, 32'h0);
        check_eq("rst/err", {31'b0, bus_if.resp_err}, 32'h0);
        check_eq("rst/rd", bus_if.rd_data, 32'h0);
        bus_if.req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check_eq("idle/ready", {31'b0, bus_if.req_ready}, 32'h1);
        check_eq("idle/valid", {31'b0, bus_if.resp_valid}, 32'h0);

        // Aligned word
        run("st_word", 1'b0, 1'b1, 3'd4, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 1, 1'b0);
        run("ld_word", 1'b1, 1'b0, 3'd4, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 1, 1'b1);

        // Byte / half lanes (upper store bytes must be ignored)
        run("st_byte", 1'b0, 1'b1, 3'd1, 32'h12, 32'hFFFF_FF55, 32'h0, 1'b0, 1, 1'b0);
        run("ld_w4", 1'b1, 1'b0, 3'd4, 32'h10, 32'h0, 32'hDE55_BEEF, 1'b0, 1, 1'b1);
        run("ld_half", 1'b1, 1'b0, 3'd2, 32'h12, 32'h0, 32'h0000_DE55, 1'b0, 1, 1'b1);
        run("ld_byte", 1'b1, 1'b0, 3'd1, 32'h13, 32'h0, 32'h0000_00DE, 1'b0, 1, 1'b1);

        // Split across words, including wrap from word 255 to word 0
        run("st_w0", 1'b0, 1'b1, 3'd4, 32'h0, 32'h1122_3344, 32'h0, 1'b0, 1, 1'b0);
        run("st_w255", 1'b0, 1'b1, 3'd4, 32'h3FC, 32'h5566_7788, 32'h0, 1'b0, 1, 1'b0);
        run("st_split", 1'b0, 1'b1, 3'd4, 32'h3FE, 32'hAABB_CCDD, 32'h0, TRAP, TRAP ? 1 : 2, 1'b0);
        run("ld_w255", 1'b1, 1'b0, 3'd4, 32'h3FC, 32'h0,
            TRAP ? 32'h5566_7788 : 32'hCCDD_7788, 1'b0, 1, 1'b1);
        run("ld_w0", 1'b1, 1'b0, 3'd4, 32'h0, 32'h0,
            TRAP ? 32'h1122_3344 : 32'h1122_AABB, 1'b0, 1, 1'b1);
        run("ld_split", 1'b1, 1'b0, 3'd4, 32'h3FE, 32'h0,
            TRAP ? 32'h0 : 32'hAABB_CCDD, TRAP, TRAP ? 1 : 2, 1'b1);
        run("ld_wrap", 1'b1, 1'b0, 3'd4, 32'h400, 32'h0,
            TRAP ? 32'h1122_3344 : 32'h1122_AABB, 1'b0, 1, 1'b1);
        run("st_half_x", 1'b0, 1'b1, 3'd2, 32'h13, 32'h1234_9988, 32'h0, TRAP, TRAP ? 1 : 2, 1'b0);
        run("ld_half_x", 1'b1, 1'b0, 3'd2, 32'h13, 32'h0,
            TRAP ? 32'h0 : 32'h0000_9988, TRAP, TRAP ? 1 : 2, 1'b1);
        w4 = TRAP ? 32'hDE55_BEEF : 32'h8855_BEEF;
        run("ld_w4b", 1'b1, 1'b0, 3'd4, 32'h10, 32'h0, w4, 1'b0, 1, 1'b1);

        // Illegal requests: bad size, both opcodes, no opcode
        run("ill_size", 1'b0, 1'b1, 3'd3, 32'h10, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        run("ill_ldst", 1'b1, 1'b1, 3'd4, 32'h10, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        run("ill_none", 1'b0, 1'b0, 3'd4, 32'h10, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        run("ill_ld0", 1'b1, 1'b0, 3'd0, 32'h10, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        run("ill_chk", 1'b1, 1'b0, 3'd4, 32'h10, 32'h0, w4, 1'b0, 1, 1'b1);

        // Handshake: req_valid held high for 12 cycles -> one accept per 3 cycles
        @(negedge clk);
        bus_if.req_valid = 1'b1;
        bus_if.load      = 1'b1;
        bus_if.store     = 1'b0;
        bus_if.xfer_size = 3'd4;
        bus_if.address   = 32'h10;
        acc = 0; rsp = 0; ov = 0; bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus_if.req_ready) acc++;
            if (bus_if.resp_valid) rsp++;
            if (bus_if.req_ready && bus_if.resp_valid) ov++;
            if (bus_if.resp_valid && (bus_if.rd_data !== w4)) bad++;
            @(negedge clk);
        end
        bus_if.req_valid = 1'b0;
        check_eq("hs/accepts", 32'(acc), 32'd4);
        check_eq("hs/resps", 32'(rsp), 32'd4);
        check_eq("hs/overlap", 32'(ov), 32'd0);
        check_eq("hs/rd_bad", 32'(bad), 32'd0);
        repeat (2) @(negedge clk);

        // Reset in the middle of a split store
        run("pre_w255", 1'b0, 1'b1, 3'd4, 32'h3FC, 32'h0102_0304, 32'h0, 1'b0, 1, 1'b0);
        run("pre_w0", 1'b0, 1'b1, 3'd4, 32'h0, 32'h0506_0708, 32'h0, 1'b0, 1, 1'b0);
        @(negedge clk);
        bus_if.req_valid = 1'b1;
        bus_if.load      = 1'b0;
        bus_if.store     = 1'b1;
        bus_if.xfer_size = 3'd4;
        bus_if.address   = 32'h3FE;
        bus_if.wr_data   = 32'hAABB_CCDD;
        n = 0;
        while (!bus_if.req_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        @(negedge clk);
        check_eq("mid/valid", {31'b0, bus_if.resp_valid}, {31'b0, TRAP});
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid/rst_valid", {31'b0, bus_if.resp_valid}, 32'h0);
        check_eq("mid/rst_err", {31'b0, bus_if.resp_err}, 32'h0);
        check_eq("mid/rst_rd", bus_if.rd_data, 32'h0);
        check_eq("mid/rst_ready", {31'b0, bus_if.req_ready}, 32'h0);
        reset = 1'b0;
        rsp = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus_if.resp_valid) rsp++;
        end
        check_eq("mid/no_resp", 32'(rsp), 32'd0);
        run("post_w255", 1'b1, 1'b0, 3'd4, 32'h3FC, 32'h0,
            TRAP ? 32'h0102_0304 : 32'hCCDD_0304, 1'b0, 1, 1'b1);
        run("post_w0", 1'b1, 1'b0, 3'd4, 32'h0, 32'h0, 32'h0506_0708, 1'b0, 1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
